hex_line_loader: RTL

Line-oriented controller for the UART-to-7-segment display path. Consumes received bytes signalled by the UART receiver's toggle handshake, classifies them as ASCII hex digits, assembles up to DIGITS nibbles into a staging buffer, and commits the line atomically to the display value on CR/LF. Malformed lines, overlong lines and stale partial lines are discarded. The display scanner never sees a half-entered number.

---
 rtl/hex_line_pkg.sv | 24 ++
 rtl/ascii_hex_classify.sv | 29 ++
 rtl/hex_line_loader.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/hex_line_pkg.sv
// Shared definitions for the hex line loader and other ASCII decode users:
// control characters, loader state encoding and byte classes.
package hex_line_pkg;

    localparam logic [7:0] ASCII_CR  = 8'h0D;
    localparam logic [7:0] ASCII_LF  = 8'h0A;
    localparam logic [7:0] ASCII_BS  = 8'h08;
    localparam logic [7:0] ASCII_DEL = 8'h7F;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_COMMIT,
        ST_DRAIN
    } state_e;

    typedef enum logic [1:0] {
        CLS_HEX,
        CLS_EOL,
        CLS_BS,
        CLS_INV
    } byte_cls_e;

endpackage

// File: rtl/ascii_hex_classify.sv
// Combinational ASCII byte classifier: hex digit (with nibble), end of line,
// backspace/delete, or anything else.
module ascii_hex_classify
    import hex_line_pkg::*;
(
    input  logic [7:0] byte_i,
    output byte_cls_e  cls_o,
    output logic [3:0] nib_o
);

    always_comb begin
        cls_o = CLS_INV;
        nib_o = 4'h0;
        if (byte_i >= 8'h30 && byte_i <= 8'h39) begin
            cls_o = CLS_HEX;
            nib_o = byte_i[3:0];
        end else if ((byte_i >= 8'h41 && byte_i <= 8'h46) ||
                     (byte_i >= 8'h61 && byte_i <= 8'h66)) begin
            // 'A'/'a' have low nibble 1, so +9 yields 10..15
            cls_o = CLS_HEX;
            nib_o = byte_i[3:0] + 4'd9;
        end else if (byte_i == ASCII_CR || byte_i == ASCII_LF) begin
            cls_o = CLS_EOL;
        end else if (byte_i == ASCII_BS || byte_i == ASCII_DEL) begin
            cls_o = CLS_BS;
        end
    end

endmodule

// File: rtl/hex_line_loader.sv
// Assembles hex digits from the UART toggle handshake into a staging buffer
// and commits whole lines to the display. Define HEX_LINE_BACKSPACE_EN for BS editing.
module hex_line_loader
    import hex_line_pkg::*;
#(
    parameter int DIGITS      = 4,
    parameter int TIMEOUT_CYC = 50_000_000
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [7:0]                   rx_data,
    input  logic                         rx_toggle,
    output logic [4*DIGITS-1:0]          disp_value,
    output logic                         disp_valid,
    output logic                         commit_pulse,
    output logic                         error_pulse,
    output logic [$clog2(DIGITS+1)-1:0]  digit_count,
    output logic                         busy
);

    localparam int SW = 4 * DIGITS;
    localparam int CW = $clog2(DIGITS + 1);
    localparam int TW = $clog2(TIMEOUT_CYC);
    localparam logic [TW-1:0] TOUT = TW'(TIMEOUT_CYC - 1);

    state_e          state_q, state_d;
    logic            prev_q, prev_d;
    logic [SW-1:0]   staging_q, staging_d;
    logic [CW-1:0]   count_q, count_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [SW-1:0]   disp_q, disp_d;
    logic            dvalid_q, dvalid_d;
    logic            commit_q, commit_d;
    logic            err_q, err_d;

    byte_cls_e       cls, cls_eff;
    logic [3:0]      nib;
    logic            ev;
    logic            tout;

    ascii_hex_classify u_cls (
        .byte_i (rx_data),
        .cls_o  (cls),
        .nib_o  (nib)
    );

`ifdef HEX_LINE_BACKSPACE_EN
    assign cls_eff = cls;
`else
    assign cls_eff = (cls == CLS_BS) ? CLS_INV : cls;
`endif

    // A toggle seen during COMMIT stays pending until the following edge
    assign ev   = (rx_toggle != prev_q) && (state_q != ST_COMMIT);
    assign tout = !ev && (timer_q == TOUT);

    always_comb begin
        state_d   = state_q;
        prev_d    = prev_q;
        staging_d = staging_q;
        count_d   = count_q;
        timer_d   = '0;
        disp_d    = disp_q;
        dvalid_d  = dvalid_q;
        commit_d  = 1'b0;
        err_d     = 1'b0;

        if (ev) begin
            prev_d = rx_toggle;
        end else if (state_q == ST_COLLECT || state_q == ST_DRAIN) begin
            timer_d = timer_q + TW'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (ev) begin
                    if (cls_eff == CLS_HEX) begin
                        staging_d      = staging_q << 4;
                        staging_d[3:0] = nib;
                        count_d        = count_q + CW'(1);
                        state_d        = ST_COLLECT;
                    end else if (cls_eff == CLS_INV) begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_COLLECT: begin
                if (ev) begin
                    case (cls_eff)
                        CLS_HEX: begin
                            if (count_q == CW'(DIGITS)) begin
                                err_d   = 1'b1;
                                state_d = ST_DRAIN;
                            end else begin
                                staging_d      = staging_q << 4;
                                staging_d[3:0] = nib;
                                count_d        = count_q + CW'(1);
                            end
                        end
                        CLS_EOL: state_d = ST_COMMIT;
                        CLS_BS: begin
                            staging_d = staging_q >> 4;
                            count_d   = count_q - CW'(1);
                            if (count_q == CW'(1)) state_d = ST_IDLE;
                        end
                        default: begin
                            err_d   = 1'b1;
                            state_d = ST_DRAIN;
                        end
                    endcase
                end else if (tout) begin
                    staging_d = '0;
                    count_d   = '0;
                    state_d   = ST_IDLE;
                end
            end
            ST_COMMIT: begin
                disp_d    = staging_q;
                dvalid_d  = 1'b1;
                commit_d  = 1'b1;
                staging_d = '0;
                count_d   = '0;
                state_d   = ST_IDLE;
            end
            default: begin
                // DRAIN keeps the rejected digits visible until EOL or timeout
                if ((ev && cls_eff == CLS_EOL) || tout) begin
                    staging_d = '0;
                    count_d   = '0;
                    state_d   = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            prev_q    <= 1'b0;
            staging_q <= '0;
            count_q   <= '0;
            timer_q   <= '0;
            disp_q    <= '0;
            dvalid_q  <= 1'b0;
            commit_q  <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            prev_q    <= prev_d;
            staging_q <= staging_d;
            count_q   <= count_d;
            timer_q   <= timer_d;
            disp_q    <= disp_d;
            dvalid_q  <= dvalid_d;
            commit_q  <= commit_d;
            err_q     <= err_d;
        end
    end

    assign disp_value   = disp_q;
    assign disp_valid   = dvalid_q;
    assign commit_pulse = commit_q;
    assign error_pulse  = err_q;
    assign digit_count  = count_q;
    assign busy         = (state_q != ST_IDLE);

endmodule
